// File: rtl/btn_debounce_pkg.sv
// btn_debounce_pkg: shared FSM state encoding and default timing parameters
package btn_debounce_pkg;
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_LONG_CYCLES     = 100000000;
endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input bit
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: debounces a push-button and emits press, release and long-press strobes
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_err
        $error("btn_debounce: requires DEBOUNCE_CYCLES>=2 and LONG_CYCLES>DEBOUNCE_CYCLES");
    end

    logic          btn_s;
    state_t        state_q, state_d;
    logic [DW-1:0] db_q, db_d;
    logic [LW-1:0] hold_q, hold_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    sync_2ff u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_in),
        .q    (btn_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            db_q        <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_q        <= db_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        db_d        = db_q;
        hold_d      = hold_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d     = PRESS_WAIT;
                    db_d        = '0;
                    hold_d      = '0;
                    long_done_d = 1'b0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (db_q == DB_MAX) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            PRESSED: begin
                // hold counter saturates at LONG_MAX; the long strobe fires once there
                if (hold_q != LONG_MAX) begin
                    hold_d = hold_q + 1'b1;
                end else if (!long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    db_d    = '0;
                end
            end
            RELEASE_WAIT: begin
                if (hold_q != LONG_MAX) hold_d = hold_q + 1'b1;
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (db_q == DB_MAX) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
        endcase
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable synchronised samples needed to accept a level change (10 ms at 100 MHz).
REQ-002 Parameter LONG_CYCLES, default 100000000, is the number of held cycles in PRESSED before a long-press event (1 s at 100 MHz).
REQ-003 clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 btn_in  input  1  raw, bouncing, asynchronous push-button level (1 = pressed).
REQ-006 btn_level  output  1  debounced button level.
REQ-007 press_pulse  output  1  one-cycle strobe on an accepted press; this is the clean edge for the downstream direction-toggle/counter stage.
REQ-008 release_pulse  output  1  one-cycle strobe on an accepted release.
REQ-009 long_pulse  output  1  one-cycle strobe, at most once per press, after LONG_CYCLES of continuous hold.

Function
REQ-010 btn_in SHALL pass through a two-flop synchroniser; its output btn_s is the only signal the FSM uses.
REQ-011 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-012 IDLE: btn_s=1 -> PRESS_WAIT with the stability counter cleared.
REQ-013 PRESS_WAIT: btn_s=0 -> IDLE with no output change (bounce rejected); otherwise the counter increments.
REQ-014 PRESS_WAIT -> PRESSED SHALL occur when the counter reaches DEBOUNCE_CYCLES-1 with btn_s=1; btn_level rises and press_pulse is high for exactly that one cycle.
REQ-015 Latency SHALL be exactly DEBOUNCE_CYCLES+2 cycles from the first clk edge sampling btn_in=1 (clean input) to press_pulse high.
REQ-016 PRESSED: the hold counter increments every cycle; on reaching LONG_CYCLES-1, long_pulse is high for one cycle, then the counter saturates with no further long_pulse this press.
REQ-017 PRESSED: btn_s=0 -> RELEASE_WAIT with the stability counter cleared; the hold counter keeps running.
REQ-018 RELEASE_WAIT: btn_s=1 -> PRESSED with no output change (bounce rejected); after DEBOUNCE_CYCLES consecutive btn_s=0 -> IDLE, btn_level falls and release_pulse is high for one cycle.
REQ-019 The hold counter SHALL clear only on entry to PRESS_WAIT.
REQ-020 press_pulse, release_pulse and long_pulse SHALL be registered, mutually exclusive and never high on consecutive cycles.
REQ-021 Counter widths SHALL be $clog2 of the respective parameter; counters SHALL never wrap.
REQ-022 Parameter legality: DEBOUNCE_CYCLES>=2 and LONG_CYCLES>DEBOUNCE_CYCLES; violation SHALL be an elaboration error.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, both counters 0, synchroniser flops 0, and all four outputs 0.
REQ-024 Reset asserted mid-press SHALL abort with no release_pulse; a button still held after reset release SHALL be re-qualified through PRESS_WAIT and produce a normal press_pulse.

Structure
REQ-025 A shared package SHALL hold the state encoding constants and default parameter values.
REQ-026 The synchroniser SHALL be a separate sub-module, sync_2ff, with ports clk, rst_n, d and q.

Verification (DEBOUNCE_CYCLES=8, LONG_CYCLES=32)
REQ-027 Clean press: btn_in rises and holds -> press_pulse a single cycle exactly 10 cycles later; btn_level=1 from that cycle.
REQ-028 Press bounce: btn_in toggles 1/0 every 3 cycles for 30 cycles, then holds 1 -> no pulse during bouncing; one press_pulse 10 cycles after the final rise.
REQ-029 Long press: hold 60 cycles -> press_pulse at cycle 10, one long_pulse 32 cycles after press_pulse, none afterwards.
REQ-030 Release bounce: while pressed, btn_in low 5 cycles then high -> no release_pulse, btn_level stays 1; then low 20 cycles -> one release_pulse, btn_level=0.
REQ-031 Reset mid-press: rst_n low 3 cycles while btn_level=1, btn_in held -> all outputs 0 at once, no release_pulse; fresh press_pulse 10 cycles after rst_n rises.
